fifo_stream_reader: RTL and testbench

- Read-side controller that drains a FIFO and turns its words into a valid/ready stream for downstream compute blocks.
- The FIFO interface it drives is rden/empty with registered o_data: a read issued while not empty returns its word on o_data in the following cycle, and o_data holds otherwise.
- A start pulse programs a burst length; the block pops exactly that many words, flags the last one, and pulses done.
- A 2-entry output buffer absorbs the FIFO's 1-cycle read latency and downstream backpressure, sustaining 1 word/cycle.

---
 rtl/fifo_stream_reader.sv | 134 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Drains a programmed number of words from a registered-output
//               FIFO and presents them as a valid/ready stream with last/done.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 255,
  parameter int LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_rden,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam logic [1:0]       c_IDLE    = 2'd0;
  localparam logic [1:0]       c_RUN     = 2'd1;
  localparam logic [1:0]       c_DRAIN   = 2'd2;
  localparam logic [LEN_W-1:0] c_LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_issued;
  logic [LEN_W-1:0]      r_delivered;
  logic                  r_inflight;
  logic                  r_done;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;

  logic       w_pop;
  logic       w_rden;
  logic       w_room;
  logic       w_last_hs;
  logic [2:0] w_fill;

  // Words issued but not yet popped (buffered + in flight) may never exceed 2.
  assign w_pop     = out_valid & out_ready;
  assign w_fill    = {1'b0, r_occ} + {2'b00, r_inflight} + 3'd1;
  assign w_room    = (w_fill <= (3'd2 + {2'b00, w_pop}));
  assign w_rden    = (r_state == c_RUN) & ~fifo_empty & (r_issued < r_len) & w_room;
  assign w_last_hs = w_pop & out_last;

  assign fifo_rden = w_rden;
  assign busy      = (r_state != c_IDLE);
  assign done      = r_done;
  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_head;
  assign out_last  = out_valid & (r_delivered == (r_len - c_LEN_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_rden) r_issued <= r_issued + c_LEN_ONE;
      if (w_pop)  r_delivered <= r_delivered + c_LEN_ONE;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if (burst_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_len       <= burst_len;
              r_issued    <= '0;
              r_delivered <= '0;
              r_state     <= c_RUN;
            end
          end
        end
        c_RUN: begin
          if (w_rden && ((r_issued + c_LEN_ONE) == r_len)) r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          if (w_last_hs) begin
            r_state <= c_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Head register feeds out_data directly so it holds once the buffer empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_inflight <= w_rden;
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= fifo_rdata;
          else               r_skid <= fifo_rdata;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd2) r_head <= r_skid;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= fifo_rdata;
          end else begin
            r_head <= r_skid;
            r_skid <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Directed self-checking bench for fifo_stream_reader with a
//               behavioural registered-output FIFO and a stream monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          out_ready = 1'b0;
  logic          busy, done, fifo_empty, fifo_rden, out_valid, out_last;
  logic [DW-1:0] fifo_rdata, out_data;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int          rden_cnt = 0, pop_cnt = 0, done_cnt = 0;
  int          ov_viol = 0, empty_viol = 0, stab_viol = 0, outstanding = 0;
  bit          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [DW-1:0] got_data[$];
  bit          got_last[$];

  fifo_stream_reader #(.DATA_WIDTH(DW), .MAX_BURST(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
    .fifo_rdata(fifo_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rdata <= '0;
    end else if (fifo_rden && !fifo_empty) begin
      fifo_rdata <= mem[rd_ptr % 512];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Outstanding = words read from the FIFO but not yet accepted downstream.
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (fifo_rden) begin
        rden_cnt++;
        if (fifo_empty) empty_viol++;
        if (outstanding - ((out_valid && out_ready) ? 1 : 0) + 1 > 2) ov_viol++;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stab_viol++;
      if (out_valid && out_ready) begin
        pop_cnt++;
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      outstanding = outstanding + (fifo_rden ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
      prev_last   = out_last;
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr % 512] = v;
    wr_ptr++;
  endtask

  task automatic start_burst(input int n);
    start     = 1'b1;
    burst_len = n[LW-1:0];
    cyc();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      cyc();
    end
  endtask

  initial begin
    bit ok;
    int base_pop, base_done, base_rden, base_ov, base_stab, base_empty, saved_rd, bad, n;
    logic [DW-1:0] exp_b;

    // ---------------- reset with a non-empty FIFO and ready downstream
    out_ready = 1'b1;
    push(8'hEE);
    cyc();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_fifo_rden", fifo_rden, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    chk("idle_fifo_rden", fifo_rden, 1'b0);
    cyc();
    wr_ptr = rd_ptr;

    // ---------------- burst of 4, cycle-exact timing
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    start_burst(4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("b4_rden_c%0d", k), fifo_rden, (k <= 4));
      chk($sformatf("b4_valid_c%0d", k), out_valid, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk($sformatf("b4_data_c%0d", k), out_data, 32'h11 * (k - 2));
      chk($sformatf("b4_last_c%0d", k), out_last, (k == 6));
      chk($sformatf("b4_done_c%0d", k), done, (k == 7));
      chk($sformatf("b4_busy_c%0d", k), busy, (k <= 6));
      cyc();
    end

    // ---------------- backpressure, burst of 6 with ready 1,0,0,...
    base_pop = got_data.size(); base_done = done_cnt; base_ov = ov_viol; base_stab = stab_viol;
    for (int i = 0; i < 6; i++) push(8'hA1 + 8'(i));
    start_burst(6);
    ok = 1'b0;
    for (int k = 1; k < 80 && !ok; k++) begin
      out_ready = ((k - 1) % 3 == 0);
      @(negedge clk);
      if (done) ok = 1'b1;
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_done_seen", ok, 1'b1);
    chk("bp_count", got_data.size() - base_pop, 6);
    bad = 0;
    for (int i = 0; i < 6 && base_pop + i < got_data.size(); i++) begin
      if (got_data[base_pop + i] !== 8'hA1 + 8'(i)) bad++;
      if (got_last[base_pop + i] !== (i == 5)) bad++;
    end
    chk("bp_order_last", bad, 0);
    chk("bp_overfill", ov_viol - base_ov, 0);
    chk("bp_stable", stab_viol - base_stab, 0);
    chk("bp_done_once", done_cnt - base_done, 1);

    // ---------------- empty FIFO stall, burst of 3
    base_pop = got_data.size(); base_done = done_cnt; base_empty = empty_viol;
    push(8'hB1);
    start_burst(3);
    @(negedge clk); chk("es_rden_c1", fifo_rden, 1'b1); cyc();
    @(negedge clk); chk("es_rden_c2", fifo_rden, 1'b0); chk("es_busy_c2", busy, 1'b1); cyc();
    @(negedge clk);
    chk("es_valid_c3", out_valid, 1'b1);
    chk("es_data_c3", out_data, 8'hB1);
    chk("es_last_c3", out_last, 1'b0);
    cyc();
    @(negedge clk); chk("es_rden_c4", fifo_rden, 1'b0); cyc();
    push(8'hB2); push(8'hB3);
    wait_done(30, ok);
    cyc(); cyc();
    chk("es_done_seen", ok, 1'b1);
    chk("es_count", got_data.size() - base_pop, 3);
    bad = 0;
    for (int i = 0; i < 3 && base_pop + i < got_data.size(); i++) begin
      if (got_data[base_pop + i] !== 8'hB1 + 8'(i)) bad++;
      if (got_last[base_pop + i] !== (i == 2)) bad++;
    end
    chk("es_order_last", bad, 0);
    chk("es_rden_when_empty", empty_viol - base_empty, 0);
    chk("es_done_once", done_cnt - base_done, 1);

    // ---------------- burst_len = 0
    push(8'hC0);
    saved_rd = rd_ptr;
    start_burst(0);
    @(negedge clk);
    chk("z_done_c1", done, 1'b1);
    chk("z_busy_c1", busy, 1'b0);
    chk("z_rden_c1", fifo_rden, 1'b0);
    cyc();
    @(negedge clk);
    chk("z_done_c2", done, 1'b0);
    cyc();
    chk("z_no_reads", rd_ptr - saved_rd, 0);
    wr_ptr = rd_ptr;

    // ---------------- start while busy is ignored
    base_pop = got_data.size(); base_done = done_cnt; base_rden = rden_cnt;
    for (int i = 0; i < 5; i++) push(8'hD1 + 8'(i));
    start_burst(2);
    start = 1'b1; burst_len = 8'd5;
    cyc();
    start = 1'b0;
    wait_done(30, ok);
    for (int i = 0; i < 6; i++) cyc();
    chk("sb_done_seen", ok, 1'b1);
    chk("sb_count", got_data.size() - base_pop, 2);
    chk("sb_rden", rden_cnt - base_rden, 2);
    chk("sb_done_once", done_cnt - base_done, 1);
    chk("sb_busy_after", busy, 1'b0);
    if (got_data.size() - base_pop >= 2) begin
      chk("sb_word1", got_data[base_pop + 1], 8'hD2);
      chk("sb_last1", got_last[base_pop + 1], 1'b1);
    end
    wr_ptr = rd_ptr;

    // ---------------- max burst 255
    base_pop = got_data.size(); base_rden = rden_cnt;
    for (int i = 0; i < 255; i++) push(8'((i * 7 + 3) & 255));
    start_burst(255);
    wait_done(400, ok);
    cyc();
    chk("max_done_seen", ok, 1'b1);
    chk("max_count", got_data.size() - base_pop, 255);
    chk("max_rden", rden_cnt - base_rden, 255);
    bad = 0;
    for (int i = 0; i < 255 && base_pop + i < got_data.size(); i++) begin
      exp_b = 8'((i * 7 + 3) & 255);
      if (got_data[base_pop + i] !== exp_b) bad++;
      if (got_last[base_pop + i] !== (i == 254)) bad++;
    end
    chk("max_data_last", bad, 0);

    // ---------------- reset mid-burst after 2 of 5 words
    for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
    start_burst(5);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      if (n == 2) ok = 1'b1;
      cyc();
    end
    chk("rm_two_popped", ok, 1'b1);
    rst_n  = 1'b0;
    wr_ptr = rd_ptr;
    #1;
    chk("rm_busy", busy, 1'b0);
    chk("rm_valid", out_valid, 1'b0);
    chk("rm_data", out_data, 8'h00);
    chk("rm_last", out_last, 1'b0);
    chk("rm_rden", fifo_rden, 1'b0);
    chk("rm_done", done, 1'b0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    base_pop = got_data.size(); base_done = done_cnt;
    push(8'h5A); push(8'hA5);
    start_burst(2);
    wait_done(20, ok);
    cyc();
    chk("pr_done_seen", ok, 1'b1);
    chk("pr_count", got_data.size() - base_pop, 2);
    chk("pr_done_once", done_cnt - base_done, 1);
    if (got_data.size() - base_pop >= 2) begin
      chk("pr_word0", got_data[base_pop], 8'h5A);
      chk("pr_word1", got_data[base_pop + 1], 8'hA5);
      chk("pr_last0", got_last[base_pop], 1'b0);
      chk("pr_last1", got_last[base_pop + 1], 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
